// File: rtl/network_types.sv
// network_types: shared types and defaults for the network TX path.
//   DATA_BITS_DEF / DEPTH_DEF : default beat width and packet-buffer depth.
//   net_tx_beat_t             : one stored TX beat {data, keep, last}; the
//                               packet buffer packs its RAM words in this order.
//   tx_wr_state_e             : write-side FSM (accept beats / discard oversize).
//   tx_rd_state_e             : read-side FSM (idle / streaming packets out).
package network_types;

  localparam int DATA_BITS_DEF = 512;
  localparam int DEPTH_DEF     = 256;

  typedef struct packed {
    logic [DATA_BITS_DEF-1:0]   data;
    logic [DATA_BITS_DEF/8-1:0] keep;
    logic                       last;
  } net_tx_beat_t;

  typedef enum logic {
    WS_WR   = 1'b0,
    WS_DROP = 1'b1
  } tx_wr_state_e;

  typedef enum logic {
    RS_IDLE   = 1'b0,
    RS_STREAM = 1'b1
  } tx_rd_state_e;

endpackage

// File: rtl/tx_pkt_ram.sv
// tx_pkt_ram: inferred simple dual-port RAM with a registered read port.
//   net_clk          : clock for both ports.
//   wr_en/addr/data  : write port, written on the rising edge.
//   rd_en/addr       : read request; rd_data holds the word one cycle later
//                      and keeps it until the next read request.
module tx_pkt_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     net_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge net_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/network_tx_pkt_fifo.sv
// network_tx_pkt_fifo: store-and-forward TX packet buffer (net_clk domain).
// A packet is released to m_axis only once its last beat is stored, so the
// downstream MAC never sees a valid gap inside a packet. Packets longer than
// the buffer are discarded whole and counted.
//   net_clk, net_rst : clock, synchronous active-high reset.
//   s_axis_*         : TX beats in (tvalid/tready/tdata/tkeep/tlast).
//   m_axis_*         : TX beats out, same fields.
//   occupancy        : beats held (including an uncommitted partial packet),
//                      registered, one cycle behind the pointers.
//   pkt_cnt          : packets fully sent on m_axis (wraps).
//   drop_cnt         : oversize packets discarded (wraps).
// Handshake: a beat transfers on a rising edge where tvalid and tready are both
// high; tvalid never waits for tready, and data/keep/last hold while tvalid is
// high without tready.
module network_tx_pkt_fifo
  import network_types::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_BITS  = 32
) (
  input  logic                   net_clk,
  input  logic                   net_rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_BITS-1:0]    pkt_cnt,
  output logic [CNT_BITS-1:0]    drop_cnt
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int BEAT_W    = DATA_BITS + KEEP_BITS + 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int PTR_W     = AW + 1;
  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

  tx_wr_state_e wr_state, wr_state_nxt;
  tx_rd_state_e rd_state, rd_state_nxt;

  // wr_ptr: next write slot (tentative), cm_ptr: end of committed packets,
  // fe_ptr: next RAM fetch, rd_ptr: next beat to leave on m_axis.
  // Space is freed only when a beat leaves m_axis, so beats sitting in the
  // output/skid registers still count as stored.
  logic [PTR_W-1:0] wr_ptr, cm_ptr, fe_ptr, rd_ptr;
  logic [PTR_W-1:0] pcnt, pcnt_nxt;
  logic [PTR_W-1:0] used, uncommitted;

  logic              s_acc, wr_beat, commit, overflow, drop_done;
  logic              pop, done, rd_en, rd_pend, room;
  logic [1:0]        slots;
  logic              sk_valid;
  logic [BEAT_W-1:0] sk_beat, ram_q;

  assign used        = wr_ptr - rd_ptr;
  assign uncommitted = wr_ptr - cm_ptr;

  assign s_axis_tready = !net_rst && (wr_state == WS_DROP || used < DEPTH_P);
  assign s_acc         = s_axis_tvalid && s_axis_tready;
  assign wr_beat       = s_acc && (wr_state == WS_WR);
  assign commit        = wr_beat && s_axis_tlast;
  // This beat would fill the whole buffer without ending the packet.
  assign overflow      = wr_beat && !s_axis_tlast && (uncommitted == LAST_SLOT);
  assign drop_done     = s_acc && (wr_state == WS_DROP) && s_axis_tlast;

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign done = pop && m_axis_tlast;

  // Output register, skid and an in-flight RAM read together never exceed two
  // beats; a fetch is issued only if it still fits after this cycle's pop.
  assign slots = {1'b0, m_axis_tvalid} + {1'b0, sk_valid} + {1'b0, rd_pend}
               - {1'b0, pop};
  assign room  = slots < 2'd2;

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WS_WR:   if (overflow) wr_state_nxt = WS_DROP;
      WS_DROP: if (drop_done) wr_state_nxt = WS_WR;
      default: wr_state_nxt = WS_WR;
    endcase
  end

  always_comb begin
    pcnt_nxt = pcnt;
    if (commit && !done)      pcnt_nxt = pcnt + 1'b1;
    else if (done && !commit) pcnt_nxt = pcnt - 1'b1;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_en        = 1'b0;
    case (rd_state)
      RS_IDLE: begin
        if (pcnt != '0) begin
          rd_en        = 1'b1;
          rd_state_nxt = RS_STREAM;
        end
      end
      RS_STREAM: begin
        // Fetch runs on into following committed packets without a bubble.
        rd_en = (fe_ptr != cm_ptr) && room;
        if (done && pcnt_nxt == '0) rd_state_nxt = RS_IDLE;
      end
      default: rd_state_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      wr_state <= WS_WR;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      // Rolling back on the overflowing beat frees the space immediately.
      if (overflow || wr_state == WS_DROP) wr_ptr <= cm_ptr;
      else if (wr_beat)                    wr_ptr <= wr_ptr + 1'b1;
      if (commit)    cm_ptr   <= wr_ptr + 1'b1;
      if (drop_done) drop_cnt <= drop_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      rd_state      <= RS_IDLE;
      fe_ptr        <= '0;
      rd_ptr        <= '0;
      pcnt          <= '0;
      pkt_cnt       <= '0;
      occupancy     <= '0;
      rd_pend       <= 1'b0;
      sk_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      rd_state  <= rd_state_nxt;
      pcnt      <= pcnt_nxt;
      occupancy <= used;
      rd_pend   <= rd_en;
      if (rd_en) fe_ptr  <= fe_ptr + 1'b1;
      if (pop)   rd_ptr  <= rd_ptr + 1'b1;
      if (done)  pkt_cnt <= pkt_cnt + CNT_BITS'(1);
      // Oldest beat first: output register, then skid, then RAM read data.
      if (!m_axis_tvalid || pop) begin
        m_axis_tvalid <= sk_valid || rd_pend;
        {m_axis_tdata, m_axis_tkeep, m_axis_tlast} <= sk_valid ? sk_beat : ram_q;
        sk_valid <= sk_valid && rd_pend;
        sk_beat  <= ram_q;
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_beat  <= ram_q;
      end
    end
  end

  tx_pkt_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .net_clk (net_clk),
    .wr_en   (wr_beat),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .rd_en   (rd_en),
    .rd_addr (fe_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

endmodule
